// File: rtl/program_sequencer.sv
// Fetch-side program counter and next-address select for the 8-bit teaching CPU.
// Define PROGRAM_SEQUENCER_CALL_STACK_EN to add the call/ret return-address stack.
module program_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                sync_reset,
    input  logic                jmp,
    input  logic                jmp_nz,
    input  logic [3:0]          ir_nibble,
    input  logic                dont_jmp,
    input  logic                hold,
    input  logic                call,
    input  logic                ret,
    output logic [PC_WIDTH-1:0] pm_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic                stack_err,
    output logic [7:0]          from_PS
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] target;
    logic                jump_take;

    assign pc_inc    = pc_q + PC_WIDTH'(1);
    assign target    = {ir_nibble, {(PC_WIDTH-4){1'b0}}};
    assign jump_take = jmp | (jmp_nz & ~dont_jmp);

`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // top_q is the next write slot; it wraps so a full push overwrites the oldest
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [IW-1:0]       top_q;
    logic [IW-1:0]       top_d;
    logic [IW:0]         sp_q;
    logic [IW:0]         sp_d;
    logic                err_q;
    logic                err_d;
    logic                push;
    logic                full;
    logic                empty;

    assign full  = (sp_q == (IW+1)'(STACK_DEPTH));
    assign empty = (sp_q == '0);

    always_comb begin
        pc_d  = pc_inc;
        top_d = top_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        if (sync_reset) begin
            pc_d  = '0;
            top_d = '0;
            sp_d  = '0;
            err_d = 1'b0;
        end else if (hold) begin
            pc_d = pc_q;
        end else if (jump_take) begin
            pc_d = target;
        end else if (call) begin
            push  = 1'b1;
            pc_d  = target;
            top_d = top_q + IW'(1);
            if (full) begin
                err_d = 1'b1;
            end else begin
                sp_d = sp_q + (IW+1)'(1);
            end
        end else if (ret) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                pc_d  = stack_q[top_q - IW'(1)];
                top_d = top_q - IW'(1);
                sp_d  = sp_q - (IW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        top_q <= top_d;
        sp_q  <= sp_d;
        err_q <= err_d;
        if (push) begin
            stack_q[top_q] <= pc_inc;
        end
    end

    assign stack_err = err_q;
`else
    logic unused_call_ret;

    assign unused_call_ret = call ^ ret;

    always_comb begin
        pc_d = pc_inc;
        if (sync_reset) begin
            pc_d = '0;
        end else if (hold) begin
            pc_d = pc_q;
        end else if (jump_take) begin
            pc_d = target;
        end
    end

    assign stack_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    assign pm_addr = pc_d;
    assign pc      = pc_q;
    assign from_PS = 8'(pc_q);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a queue-based reference model
// checked every cycle, plus literal expectations along the test plan.
module tb_program_sequencer;

`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] ir_nibble;
    logic       dont_jmp;
    logic       hold;
    logic       call;
    logic       ret;
    logic [7:0] pm_addr;
    logic [7:0] pc;
    logic       stack_err;
    logic [7:0] from_PS;

    int total = 0;
    int bad   = 0;

    program_sequencer #(.PC_WIDTH(8), .STACK_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .sync_reset(sync_reset),
        .jmp       (jmp),
        .jmp_nz    (jmp_nz),
        .ir_nibble (ir_nibble),
        .dont_jmp  (dont_jmp),
        .hold      (hold),
        .call      (call),
        .ret       (ret),
        .pm_addr   (pm_addr),
        .pc        (pc),
        .stack_err (stack_err),
        .from_PS   (from_PS)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: integer pc, a plain queue as return stack
    int m_pc;
    bit m_err;
    bit m_ok = 1'b0;
    int stk[$];

    function automatic int exp_next();
        int inc = (m_pc + 1) % 256;
        if (sync_reset) return 0;
        if (hold) return m_pc;
        if (jmp || (jmp_nz && !dont_jmp)) return int'(ir_nibble) * 16;
        if (STK && call) return int'(ir_nibble) * 16;
        if (STK && ret) return (stk.size() > 0) ? stk[$] : inc;
        return inc;
    endfunction

    always @(posedge clk) begin
        int nxt;
        int dropped;
        if (sync_reset) begin
            m_pc  = 0;
            m_err = 1'b0;
            stk.delete();
            m_ok  = 1'b1;
        end else if (m_ok) begin
            nxt = exp_next();
            if (STK && !hold && !jmp && !(jmp_nz && !dont_jmp)) begin
                if (call) begin
                    if (stk.size() == DEPTH) begin
                        dropped = stk.pop_front();
                        m_err = 1'b1;
                    end
                    stk.push_back((m_pc + 1) % 256);
                end else if (ret) begin
                    if (stk.size() == 0) m_err = 1'b1;
                    else dropped = stk.pop_back();
                end
            end
            m_pc = nxt;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("mdl_pm_addr", pm_addr, exp_next());
            chk("mdl_pc", pc, m_pc);
            chk("mdl_from_ps", from_PS, m_pc);
            chk("mdl_stack_err", stack_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        jmp = 0; jmp_nz = 0; dont_jmp = 0; hold = 0;
        call = 0; ret = 0; ir_nibble = 4'h0;
    endtask

    initial begin
        idle();
        sync_reset = 1;
        tick();
        tick();
        chk("rst_pm_addr", pm_addr, 8'h00);
        chk("rst_pc", pc, 8'h00);
        chk("rst_stack_err", stack_err, 0);
        sync_reset = 0;
        #1;
        chk("first_fetch", pm_addr, 8'h01);
        chk("run_pc0", pc, 8'h00);
        tick(); chk("run_pc1", pc, 8'h01);
        tick(); chk("run_pc2", pc, 8'h02);
        tick(); chk("run_pc3", pc, 8'h03);
        chk("from_ps3", from_PS, 8'h03);

        repeat (252) tick();
        chk("wrap_pc", pc, 8'hFF);
        chk("wrap_pm", pm_addr, 8'h00);
        tick();
        chk("wrap_next", pc, 8'h00);

        jmp = 1; ir_nibble = 4'h1; tick();
        jmp = 0; tick(); tick();
        chk("pre_jmp_pc", pc, 8'h12);
        jmp = 1; ir_nibble = 4'h5; #1;
        chk("jmp_pm", pm_addr, 8'h50);
        tick();
        chk("jmp_pc", pc, 8'h50);
        jmp = 0; jmp_nz = 1; ir_nibble = 4'h3; dont_jmp = 1; tick();
        chk("jnz_not_taken", pc, 8'h51);
        dont_jmp = 0; tick();
        chk("jnz_taken", pc, 8'h30);
        jmp = 1; jmp_nz = 1; dont_jmp = 1; ir_nibble = 4'h6; tick();
        chk("jmp_and_jnz", pc, 8'h60);
        idle();

        jmp = 1; ir_nibble = 4'h4; tick();
        chk("pre_hold", pc, 8'h40);
        hold = 1; ir_nibble = 4'h9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_pm", pm_addr, 8'h40);
            tick();
            chk("hold_pc", pc, 8'h40);
        end
        idle(); tick();
        chk("hold_release", pc, 8'h41);

        sync_reset = 1; jmp = 1; ir_nibble = 4'hF; #1;
        chk("rst_jmp_pm", pm_addr, 8'h00);
        tick();
        chk("rst_jmp_pc", pc, 8'h00);
        sync_reset = 0; idle();

        jmp = 1; ir_nibble = 4'h1; tick();
        idle();
        call = 1; ir_nibble = 4'h8; tick();
        chk("call_pc", pc, STK ? 8'h80 : 8'h11);
        call = 0; ret = 1; tick();
        chk("ret_pc", pc, STK ? 8'h11 : 8'h12);
        chk("ret_err", stack_err, 0);
        idle();

        sync_reset = 1; tick(); sync_reset = 0;
        ret = 1; tick();
        chk("ret_empty_pc", pc, 8'h01);
        chk("ret_empty_err", stack_err, STK ? 1 : 0);
        idle();

        sync_reset = 1; tick(); sync_reset = 0;
        call = 1; ir_nibble = 4'h8;
        repeat (4) tick();
        chk("call4_err", stack_err, 0);
        tick();
        chk("call5_pc", pc, STK ? 8'h80 : 8'h05);
        chk("call5_err", stack_err, STK ? 1 : 0);
        call = 0; ret = 1;
        repeat (5) tick();
        chk("ret_after_ovf", pc, STK ? 8'h82 : 8'h0A);
        idle();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetch-side stage directly upstream of the instruction decoder in the 8-bit teaching CPU.
- Holds the program counter and computes the next program-memory address every cycle.
- Consumes the decoder's jmp, jmp_nz and ir_nibble, plus the ALU zero flag, and drives pm_addr to the program ROM.
- The ROM's output becomes the decoder's next_instr.

Parameters:
- PC_WIDTH, 8, width of pc and pm_addr; must be >= 5.
- STACK_DEPTH, 4, return-address stack entries; power of two, used only with the optional feature.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- sync_reset  input  1  synchronous, active-high reset.
- jmp  input  1  unconditional jump request from the decoder.
- jmp_nz  input  1  conditional jump request; taken only when dont_jmp=0.
- ir_nibble  input  4  jump target high nibble.
- dont_jmp  input  1  ALU zero flag; 1 suppresses jmp_nz.
- hold  input  1  freeze fetch (single-step/debug).
- call  input  1  push return address and jump (optional feature).
- ret  input  1  pop return address (optional feature).
- pm_addr  output  PC_WIDTH  combinational next fetch address to ROM.
- pc  output  PC_WIDTH  registered program counter.
- stack_err  output  1  sticky stack overflow/underflow flag.
- from_PS  output  8  debug tap, equal to pc[7:0].

Behaviour:
- Jump target T = {ir_nibble, (PC_WIDTH-4) zeros}; for PC_WIDTH=8, ir_nibble=4'hA gives T=8'hA0.
- pm_addr is purely combinational. It is selected by strict priority; the first matching condition wins:
  1. sync_reset: pm_addr = 0.
  2. hold: pm_addr = pc. All jump, call and ret requests in this cycle are dropped.
  3. jmp: pm_addr = T.
  4. jmp_nz && !dont_jmp: pm_addr = T.
  5. call: see Optional Feature.
  6. ret: see Optional Feature.
  7. Otherwise: pm_addr = pc + 1, modulo 2^PC_WIDTH; 8'hFF wraps to 8'h00.
- jmp_nz with dont_jmp=1 falls through to the next lower-priority case (sequential increment if nothing else is asserted).
- On every rising clk, pc <= pm_addr. A jump therefore costs zero bubbles at this stage: the target is presented to the ROM in the same cycle the request is seen.
- Reset values: pc=0, pm_addr=0 while sync_reset=1, stack pointer=0, stack_err=0, from_PS=0.
- Reset applied mid-sequence overrides hold, jmp, call and ret in that same cycle. The first fetch after reset deasserts is address 1, because pm_addr = pc + 1 with pc = 0.
- Simultaneous jmp and jmp_nz: jmp wins, and the result is the same target.
- All inputs are sampled as-is. There is no handshake; the decoder guarantees it holds ir when hold=1.

Optional Feature:
- Macro: PROGRAM_SEQUENCER_CALL_STACK_EN.
- When defined, the block contains a STACK_DEPTH-entry return-address stack with pointer sp (0..STACK_DEPTH).
- call, reached by priority:
  - Push pc+1, then pm_addr = T, sp increments.
  - When full (sp=STACK_DEPTH): the oldest entry is overwritten (circular), sp stays at STACK_DEPTH, stack_err <= 1.
- ret, reached by priority:
  - Pop: pm_addr = top entry, sp decrements.
  - When empty: pm_addr = pc + 1, sp stays 0, stack_err <= 1.
- call and ret together: call wins and ret is ignored.
- hold or a higher-priority jump suppresses the push/pop entirely; the stack is unchanged.
- stack_err clears only on sync_reset. The stack contents are not cleared by reset; sp is.
- When not defined: no stack storage is present, call and ret are ignored, and stack_err is tied to 0.

Test Plan:
- Reset then free-run: sync_reset=1 for 2 cycles, then release → pm_addr=0 during reset; pc sequence 0,1,2,3 after release; from_PS tracks pc.
- Wrap-around: run to pc=8'hFF with no requests → pm_addr=8'h00; next pc=8'h00.
- Jumps: pc=8'h12, jmp=1, ir_nibble=4'h5 → pm_addr=8'h50 same cycle, pc=8'h50 next cycle. Then jmp_nz=1, ir_nibble=4'h3, dont_jmp=1 → pc=8'h51. Repeat with dont_jmp=0 → pc=8'h30.
- Hold priority: pc=8'h40, hold=1 with jmp=1 for 3 cycles → pc stays 8'h40, pm_addr=8'h40. Release hold with no requests → pc=8'h41.
- Reset mid-jump: sync_reset=1 with jmp=1, ir_nibble=4'hF → pm_addr=0, pc=0, not 8'hF0.
- With PROGRAM_SEQUENCER_CALL_STACK_EN defined:
  - At pc=8'h10, call with ir_nibble=4'h8 → pc=8'h80. Then ret → pc=8'h11, stack_err=0.
  - 5 calls with STACK_DEPTH=4 → stack_err=1.
  - ret on an empty stack → pc increments, stack_err=1.
  - Without the macro, the same stimulus leaves pc incrementing and stack_err=0.
